// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter: the write request
// record and the grant encoding.
package rf_arb_pkg;

  localparam int RF_A_WIDTH = 5;
  localparam int RF_D_WIDTH = 32;

  typedef struct packed {
    logic [RF_A_WIDTH-1:0] addr;
    logic [RF_D_WIDTH-1:0] data;
  } rf_wr_req_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_P0   = 2'd1,
    GNT_P1   = 2'd2
  } rf_gnt_e;

endpackage

// File: rtl/rf_wr_fifo.sv
// Circular FIFO for port-1 write returns. It also exposes every slot's
// destination address with a valid bit so the top can build the pending mask.
module rf_wr_fifo
  import rf_arb_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter int  A_WIDTH = RF_A_WIDTH,
  parameter type entry_t = rf_wr_req_t,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            push,
  input  entry_t                          push_entry,
  input  logic                            pop,
  output entry_t                          head,
  output logic                            full,
  output logic                            empty,
  output logic [CNT_W-1:0]                count,
  output logic [DEPTH-1:0][A_WIDTH-1:0]   entry_addr,
  output logic [DEPTH-1:0]                entry_vld
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t [DEPTH-1:0] mem_r;
  logic   [DEPTH-1:0] vld_r;
  logic   [PTR_W-1:0] rd_ptr_r;
  logic   [PTR_W-1:0] wr_ptr_r;
  logic   [CNT_W-1:0] count_r;
  logic               push_s;
  logic               pop_s;

  assign empty  = (count_r == CNT_W'(0));
  assign full   = (count_r == CNT_W'(DEPTH));
  assign count  = count_r;
  assign head   = mem_r[rd_ptr_r];
  assign pop_s  = pop & ~empty;
  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign push_s = push & (~full | pop_s);

  // Slot contents and pointers; on a simultaneous push/pop of the same slot the push wins.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_r    <= '0;
      vld_r    <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
    end else begin
      if (pop_s) begin
        vld_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r        <= rd_ptr_r + PTR_W'(1);
      end
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_entry;
        vld_r[wr_ptr_r] <= 1'b1;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
    end
  end

  // Occupancy counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_r <= '0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Per-slot address view for the pending-write mask.
  always_comb begin
    entry_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_addr[i] = mem_r[i].addr;
    end
  end

  assign entry_vld = vld_r;

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file's single write port between a stallable port-0
// writeback and a FIFO-buffered, non-stallable port-1 return path.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int A_WIDTH  = RF_A_WIDTH,
  parameter int D_WIDTH  = RF_D_WIDTH,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    p0_valid,
  output logic                    p0_ready,
  input  logic [A_WIDTH-1:0]      p0_addr,
  input  logic [D_WIDTH-1:0]      p0_data,
  input  logic                    p1_valid,
  input  logic [A_WIDTH-1:0]      p1_addr,
  input  logic [D_WIDTH-1:0]      p1_data,
  output logic                    p1_full,
  output logic                    ovf_err,
  output logic                    WE3,
  output logic [A_WIDTH-1:0]      A3,
  output logic [D_WIDTH-1:0]      WD3,
  output logic [2**A_WIDTH-1:0]   pend_mask
);

  localparam int AGE_W = $clog2(MAX_WAIT + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NREG  = 2**A_WIDTH;

  typedef struct packed {
    logic [A_WIDTH-1:0] addr;
    logic [D_WIDTH-1:0] data;
  } req_t;

  req_t                             push_entry_s;
  req_t                             head_s;
  req_t                             win_s;
  logic                             fifo_full_s;
  logic                             empty_s;
  logic [CNT_W-1:0]                 count_s;
  logic [DEPTH-1:0][A_WIDTH-1:0]    entry_addr_s;
  logic [DEPTH-1:0]                 entry_vld_s;
  logic                             head_valid_s;
  logic                             force_p1_s;
  logic                             pop_s;
  rf_gnt_e                          gnt_s;
  logic [AGE_W-1:0]                 age_r;
  logic                             ovf_r;
  logic                             we3_r;
  logic [A_WIDTH-1:0]               a3_r;
  logic [D_WIDTH-1:0]               wd3_r;
  logic [NREG-1:0]                  mask_s;

  assign push_entry_s = '{addr: p1_addr, data: p1_data};

  rf_wr_fifo #(
    .DEPTH   (DEPTH),
    .A_WIDTH (A_WIDTH),
    .entry_t (req_t)
  ) u_fifo (
    .CLK        (CLK),
    .RST        (RST),
    .push       (p1_valid),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .head       (head_s),
    .full       (fifo_full_s),
    .empty      (empty_s),
    .count      (count_s),
    .entry_addr (entry_addr_s),
    .entry_vld  (entry_vld_s)
  );

  assign head_valid_s = ~empty_s;
  // A same-address port-0 write must wait so the older FIFO write commits first.
  assign force_p1_s = (count_s == CNT_W'(DEPTH)) |
                      (age_r == AGE_W'(MAX_WAIT)) |
                      (p0_valid & (head_s.addr == p0_addr));

  // Grant selection for this cycle.
  always_comb begin
    gnt_s = GNT_NONE;
    if (head_valid_s && force_p1_s) begin
      gnt_s = GNT_P1;
    end else if (p0_valid) begin
      gnt_s = GNT_P0;
    end else if (head_valid_s) begin
      gnt_s = GNT_P1;
    end else begin
      gnt_s = GNT_NONE;
    end
  end

  // Winning request payload.
  always_comb begin
    win_s = '0;
    case (gnt_s)
      GNT_P0:  win_s = '{addr: p0_addr, data: p0_data};
      GNT_P1:  win_s = head_s;
      default: win_s = '0;
    endcase
  end

  assign pop_s    = (gnt_s == GNT_P1);
  assign p0_ready = p0_valid & (gnt_s == GNT_P0) & ~RST;
  assign p1_full  = fifo_full_s;

  // Head starvation counter: counts lost cycles, saturating at MAX_WAIT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      age_r <= '0;
    end else if (pop_s || !head_valid_s) begin
      age_r <= '0;
    end else if (age_r != AGE_W'(MAX_WAIT)) begin
      age_r <= age_r + AGE_W'(1);
    end else begin
      age_r <= age_r;
    end
  end

  // Sticky record of a port-1 push that found no room.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf_r <= 1'b0;
    end else if (p1_valid && fifo_full_s && !pop_s) begin
      ovf_r <= 1'b1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Output stage; writes to x0 are latched but never enabled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      we3_r <= 1'b0;
      a3_r  <= '0;
      wd3_r <= '0;
    end else if (gnt_s != GNT_NONE) begin
      we3_r <= (win_s.addr != A_WIDTH'(0));
      a3_r  <= win_s.addr;
      wd3_r <= win_s.data;
    end else begin
      we3_r <= 1'b0;
    end
  end

  // Pending-write mask over queued entries and the output stage.
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mask_s[entry_addr_s[i]] = mask_s[entry_addr_s[i]] | entry_vld_s[i];
    end
    mask_s[a3_r] = mask_s[a3_r] | we3_r;
    mask_s[0]    = 1'b0;
  end

  assign ovf_err   = ovf_r;
  assign WE3       = we3_r;
  assign A3        = a3_r;
  assign WD3       = wd3_r;
  assign pend_mask = mask_s;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: handshake, starvation limit, ordering,
// full-FIFO forcing, x0 suppression, pending mask and asynchronous reset.
module tb_rf_write_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        p0_valid;
  logic        p0_ready;
  logic [4:0]  p0_addr;
  logic [31:0] p0_data;
  logic        p1_valid;
  logic [4:0]  p1_addr;
  logic [31:0] p1_data;
  logic        p1_full;
  logic        ovf_err;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [31:0] pend_mask;

  int checks = 0;
  int errors = 0;

  rf_write_arbiter #(
    .A_WIDTH (5), .D_WIDTH (32), .DEPTH (4), .MAX_WAIT (8)
  ) dut (
    .CLK (CLK), .RST (RST),
    .p0_valid (p0_valid), .p0_ready (p0_ready), .p0_addr (p0_addr), .p0_data (p0_data),
    .p1_valid (p1_valid), .p1_addr (p1_addr), .p1_data (p1_data),
    .p1_full (p1_full), .ovf_err (ovf_err),
    .WE3 (WE3), .A3 (A3), .WD3 (WD3), .pend_mask (pend_mask)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    RST = 1'b1;
    p0_valid = 1'b1; p0_addr = 5'd1; p0_data = 32'h0;
    p1_valid = 1'b0; p1_addr = 5'd0; p1_data = 32'h0;
    settle();
    check("rst_we3", 64'(WE3), 64'h0);
    check("rst_a3", 64'(A3), 64'h0);
    check("rst_wd3", 64'(WD3), 64'h0);
    check("rst_mask", 64'(pend_mask), 64'h0);
    check("rst_full", 64'(p1_full), 64'h0);
    check("rst_ovf", 64'(ovf_err), 64'h0);
    check("rst_p0_ready", 64'(p0_ready), 64'h0);
    tick();
    tick();
    p0_valid = 1'b0;
    RST = 1'b0;
    tick();

    // 1: port 0 only
    p0_valid = 1'b1; p0_addr = 5'd3; p0_data = 32'hDEAD;
    settle();
    check("t1_ready", 64'(p0_ready), 64'h1);
    tick();
    p0_valid = 1'b0;
    settle();
    check("t1_we3", 64'(WE3), 64'h1);
    check("t1_a3", 64'(A3), 64'h3);
    check("t1_wd3", 64'(WD3), 64'hDEAD);
    check("t1_mask", 64'(pend_mask), 64'h8);
    tick();
    check("t1_idle_we3", 64'(WE3), 64'h0);
    check("t1_hold_a3", 64'(A3), 64'h3);

    // 2: starvation limit
    p0_valid = 1'b1; p0_addr = 5'd7; p0_data = 32'h77;
    p1_valid = 1'b1; p1_addr = 5'd4; p1_data = 32'h44;
    settle();
    check("t2_push_ready", 64'(p0_ready), 64'h1);
    tick();
    p1_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      settle();
      check($sformatf("t2_lost%0d_ready", i), 64'(p0_ready), 64'h1);
      tick();
    end
    settle();
    check("t2_forced_ready", 64'(p0_ready), 64'h0);
    check("t2_forced_mask", 64'(pend_mask), 64'h90);
    tick();
    check("t2_p1_a3", 64'(A3), 64'h4);
    check("t2_p1_wd3", 64'(WD3), 64'h44);
    check("t2_p1_we3", 64'(WE3), 64'h1);
    settle();
    check("t2_resume_ready", 64'(p0_ready), 64'h1);
    tick();
    p0_valid = 1'b0;
    check("t2_p0_a3", 64'(A3), 64'h7);
    tick();

    // 3: same-address ordering
    p1_valid = 1'b1; p1_addr = 5'd9; p1_data = 32'h1;
    tick();
    p1_valid = 1'b0;
    p0_valid = 1'b1; p0_addr = 5'd9; p0_data = 32'h2;
    settle();
    check("t3_p0_blocked", 64'(p0_ready), 64'h0);
    tick();
    check("t3_first_wd3", 64'(WD3), 64'h1);
    check("t3_first_we3", 64'(WE3), 64'h1);
    settle();
    check("t3_p0_ready", 64'(p0_ready), 64'h1);
    tick();
    p0_valid = 1'b0;
    check("t3_second_wd3", 64'(WD3), 64'h2);
    check("t3_second_a3", 64'(A3), 64'h9);
    tick();

    // 4: fill the FIFO while port 0 wins, then forced drain
    p0_valid = 1'b1; p0_addr = 5'd2; p0_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      p1_valid = 1'b1; p1_addr = 5'(10 + i); p1_data = 32'(32'hA + i);
      settle();
      check($sformatf("t4_fill%0d_ready", i), 64'(p0_ready), 64'h1);
      tick();
    end
    p1_valid = 1'b1; p1_addr = 5'd14; p1_data = 32'hE;
    settle();
    check("t4_full", 64'(p1_full), 64'h1);
    check("t4_full_ready", 64'(p0_ready), 64'h0);
    check("t4_full_mask", 64'(pend_mask), 64'h3C04);
    tick();
    p1_valid = 1'b0;
    check("t4_pop_a3", 64'(A3), 64'hA);
    check("t4_pop_wd3", 64'(WD3), 64'hA);
    check("t4_still_full", 64'(p1_full), 64'h1);
    check("t4_no_ovf", 64'(ovf_err), 64'h0);
    settle();
    check("t4_full2_ready", 64'(p0_ready), 64'h0);
    tick();
    check("t4_pop2_a3", 64'(A3), 64'hB);
    check("t4_not_full", 64'(p1_full), 64'h0);
    settle();
    check("t4_p0_back", 64'(p0_ready), 64'h1);
    p0_valid = 1'b0;
    tick();
    check("t4_drain_a3_c", 64'(A3), 64'hC);
    tick();
    check("t4_drain_a3_d", 64'(A3), 64'hD);
    tick();
    check("t4_drain_a3_e", 64'(A3), 64'hE);
    check("t4_drain_wd3_e", 64'(WD3), 64'hE);
    tick();
    check("t4_idle_we3", 64'(WE3), 64'h0);
    check("t4_idle_mask", 64'(pend_mask), 64'h0);

    // 5: x0 suppression and pending mask
    p1_valid = 1'b1; p1_addr = 5'd0; p1_data = 32'h99;
    tick();
    p1_addr = 5'd5; p1_data = 32'h55;
    tick();
    p1_valid = 1'b0;
    check("t5_x0_we3", 64'(WE3), 64'h0);
    check("t5_x0_wd3", 64'(WD3), 64'h99);
    check("t5_mask_queued", 64'(pend_mask), 64'h20);
    tick();
    check("t5_we3", 64'(WE3), 64'h1);
    check("t5_a3", 64'(A3), 64'h5);
    check("t5_mask_out", 64'(pend_mask), 64'h20);
    tick();
    check("t5_mask_clear", 64'(pend_mask), 64'h0);

    // 6: reset mid-operation
    p0_valid = 1'b1; p0_addr = 5'd6; p0_data = 32'h66;
    for (int i = 0; i < 3; i++) begin
      p1_valid = 1'b1; p1_addr = 5'(20 + i); p1_data = 32'(32'h20 + i);
      tick();
    end
    p1_valid = 1'b0;
    settle();
    check("t6_pre_mask", 64'(pend_mask), 64'h700040);
    RST = 1'b1;
    settle();
    check("t6_rst_we3", 64'(WE3), 64'h0);
    check("t6_rst_a3", 64'(A3), 64'h0);
    check("t6_rst_wd3", 64'(WD3), 64'h0);
    check("t6_rst_mask", 64'(pend_mask), 64'h0);
    check("t6_rst_ready", 64'(p0_ready), 64'h0);
    tick();
    p0_valid = 1'b0;
    RST = 1'b0;
    tick();
    check("t6_post_we3", 64'(WE3), 64'h0);
    tick();
    check("t6_post2_we3", 64'(WE3), 64'h0);
    check("t6_post_mask", 64'(pend_mask), 64'h0);
    check("t6_post_full", 64'(p1_full), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
